uart_rx_fifo: RTL and testbench

Serial receive front end for the terminal: recovers 8-bit characters from the asynchronous `RxD` line by 16x oversampling and buffers them in a small show-ahead FIFO. Sits directly upstream of the terminal core, whose `read` strobe pops one character and whose character-available indication is driven from `rx_valid`. Runs entirely in the `clk_50mhz` domain.

---
 rtl/tty_pkg.sv | 26 ++
 rtl/rx_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tty_pkg.sv
// tty_pkg: shared definitions for the terminal serial receive path.
//   - rx_state_e      : receiver FSM states (PARITY only when UART_RX_PARITY_EN)
//   - UART_OVERSAMPLE : samples per bit time
//   - calc_div()      : prescaler divider for a given clock / line rate
// Config macro: UART_RX_PARITY_EN (8E1 when defined, 8N1 otherwise).
package tty_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } rx_state_e;

  // Truncating divide; caller must keep the result >= 2.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / (baud * UART_OVERSAMPLE);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: show-ahead FIFO, power-of-two DEPTH, wrap-around pointers plus a
// separate occupancy count. Head is visible on rdata whenever non-empty.
// Ports:
//   clk, rst      clock, async active-high reset
//   push, wdata   write strobe / data (accepted when not full, or full with pop)
//   pop           read strobe (ignored while empty)
//   rdata         head entry, forced to 0 while empty
//   count         occupancy 0..DEPTH
//   full, empty   status
module rx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; empty gating keeps the head at 0 after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver feeding a show-ahead FIFO.
// Config macro: UART_RX_PARITY_EN (8E1 with live parity_err; else 8N1, parity_err = 0).
// Ports:
//   clk_50mhz   system clock, rising edge
//   rst         async active-high reset
//   RxD         async serial line, idle high
//   read        pop one character per cycle high
//   clr_err     clear sticky error flags (a same-cycle set wins)
//   rx_data     FIFO head, rx_valid FIFO non-empty, rx_count occupancy
//   overrun     byte dropped on full FIFO
//   frame_err   stop bit sampled low
//   parity_err  even-parity mismatch
module uart_rx_fifo import tty_pkg::*; #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_50mhz,
  input  logic                          rst,
  input  logic                          RxD,
  input  logic                          read,
  input  logic                          clr_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  // ---- line synchronizer (idles high so reset does not look like a start bit)
  logic rx_meta, rx_sync;
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_sync <= rx_meta;
    end
  end

  // ---- free-running oversample prescaler
  logic [PW-1:0] psc;
  logic          tick;
  assign tick = (psc == PW'(DIV-1));
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) psc <= '0;
    else     psc <= tick ? '0 : psc + 1'b1;
  end

  // ---- receiver FSM
  rx_state_e  state;
  logic [3:0] phase;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       samp;     // tick at the sample point of a full bit (phase 15)

  assign samp = tick && (phase == 4'd15);

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (tick) begin
      phase <= phase + 4'd1;
      case (state)
        IDLE:
          if (!rx_sync) begin
            phase <= '0;
            state <= START;
          end
        // Recheck at mid start bit so short glitches never launch a frame.
        START:
          if (phase == 4'd7) begin
            if (!rx_sync) begin
              phase   <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        // Phase wraps 15->0 by itself, keeping later samples at bit centres.
        DATA:
          if (phase == 4'd15) begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (phase == 4'd15) state <= STOP;
`endif
        STOP:
          if (phase == 4'd15) state <= rx_sync ? IDLE : BREAK;
        // Held-low line: no new start until the line has gone high.
        BREAK:
          if (rx_sync) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Push lands on the stop-sample edge itself so the byte is visible one cycle later.
  logic push, fe_set, ovr_set, fifo_full, fifo_empty;
  assign push    = samp && (state == STOP) && rx_sync;
  assign fe_set  = samp && (state == STOP) && !rx_sync;
  // Full implies non-empty, so a concurrent read always makes room.
  assign ovr_set = push && fifo_full && !read;

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk_50mhz),
    .rst   (rst),
    .push  (push),
    .wdata (shreg),
    .pop   (read),
    .rdata (rx_data),
    .count (rx_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;

  // ---- sticky error flags
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set ? 1'b1 : (clr_err ? 1'b0 : overrun);
      frame_err <= fe_set  ? 1'b1 : (clr_err ? 1'b0 : frame_err);
    end
  end

`ifdef UART_RX_PARITY_EN
  logic pe_set;
  // Even parity: the parity bit equals the XOR of the eight data bits.
  assign pe_set = samp && (state == PARITY) && (rx_sync != ^shreg);
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= pe_set ? 1'b1 : (clr_err ? 1'b0 : parity_err);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo. Frames are driven bit by bit on
// RxD; a byte queue models the FIFO and error flags.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 64000;
  localparam int BAUD   = 1000;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / (BAUD * 16);
  localparam int BIT    = DIV * 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RxD = 1'b1;
  logic        read = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [$clog2(DEPTH):0] rx_count;
  logic        overrun, frame_err, parity_err;

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_50mhz  (clk),
    .rst        (rst),
    .RxD        (RxD),
    .read       (read),
    .clr_err    (clr_err),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_count   (rx_count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [7:0] q[$];
  logic ovr_exp = 1'b0, fe_exp = 1'b0, pe_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [7:0] d);
    if (q.size() == DEPTH) ovr_exp = 1'b1;
    else q.push_back(d);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"},  32'(rx_count), 32'(q.size()));
    chk({tag, ".valid"},  32'(rx_valid), 32'(q.size() != 0));
    chk({tag, ".data"},   32'(rx_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk({tag, ".ovr"},    32'(overrun),  32'(ovr_exp));
    chk({tag, ".fe"},     32'(frame_err), 32'(fe_exp));
    chk({tag, ".pe"},     32'(parity_err), 32'(pe_exp));
  endtask

  task automatic pop();
    read = 1'b1;
    step();
    read = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    ovr_exp = 1'b0; fe_exp = 1'b0; pe_exp = 1'b0;
  endtask

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) step();
  endtask

  // Drives one frame; optionally raises read for one cycle at index rd_at.
  // meas = first cycle index after which rx_count changed (-1 if never).
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input int rd_at, output int meas);
    logic [10:0] fr;
    int c0;
    fr = {stop_b, par_b, d, 1'b0};
    if (NBITS == 10) fr[9] = stop_b;
    c0 = int'(rx_count);
    meas = -1;
    for (int i = 0; i < NBITS * BIT; i++) begin
      RxD  = fr[i / BIT];
      read = (i == rd_at);
      step();
      if (meas < 0 && int'(rx_count) != c0) meas = i;
    end
    read = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int m;
    send_frame(d, 1'b1, ^d, -1, m);
    model_push(d);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, m16;
    logic [7:0] d;
    logic [7:0] seq [3];

    // reset
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_state("reset");

    // read on empty is ignored
    pop();
    check_state("empty_read");

    // single byte 0x41, push inside stop bit
    send_frame(8'h41, 1'b1, ^8'h41, -1, m);
    model_push(8'h41);
    check_state("b41");
    chk("push_in_stop", 32'(m >= (NBITS-1)*BIT && m < NBITS*BIT), 32'd1);
    pop();
    check_state("b41_pop");

    // back-to-back 00 FF 55
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
    for (int i = 0; i < 3; i++) send(seq[i]);
    check_state("b2b");
    for (int i = 0; i < 3; i++) begin
      pop();
      check_state("b2b_pop");
    end

    // short low glitch: rejected, receiver still usable
    RxD = 1'b0;
    repeat (BIT / 4) step();
    idle(2 * BIT);
    check_state("glitch");
    d = 8'($urandom);
    send(d);
    check_state("after_glitch");
    pop();

    // framing error then held break
    send_frame(8'h3C, 1'b0, ^8'h3C, -1, m);
    fe_exp = 1'b1;
    check_state("frame_err");
    RxD = 1'b0;
    repeat (2 * NBITS * BIT) step();
    check_state("break");
    idle(2 * BIT);
    send(8'h12);
    check_state("after_break");
    clear_err();
    check_state("clr_fe");
    pop();

    // randomized bytes, gaps and reads
    for (int n = 0; n < 8; n++) begin
      idle($urandom_range(0, 2 * BIT));
      d = 8'($urandom);
      send(d);
      check_state("rand");
      if ($urandom_range(0, 1) == 1) begin
        pop();
        check_state("rand_pop");
      end
    end
    while (q.size() != 0) pop();
    check_state("rand_drain");

    // reset mid-frame abandons the frame
    RxD = 1'b0;
    repeat (3 * BIT) step();
    rst = 1'b1;
    RxD = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    ovr_exp = 1'b0; fe_exp = 1'b0; pe_exp = 1'b0;
    idle(NBITS * BIT);
    check_state("mid_reset");

    // overrun: 17 bytes, no reads
    for (int n = 0; n < 17; n++) send(8'($urandom));
    check_state("ovr_full");
    clear_err();
    check_state("ovr_clr");
    for (int n = 0; n < DEPTH; n++) begin
      pop();
      check_state("ovr_drain");
    end

    // second run: 17th push with a read on the same edge
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int n = 0; n < 15; n++) send(8'($urandom));
    d = 8'($urandom);
    send_frame(d, 1'b1, ^d, -1, m16);
    model_push(d);
    chk("m16_seen", 32'(m16 >= 0), 32'd1);
    d = 8'($urandom);
    send_frame(d, 1'b1, ^d, m16, m);
    void'(q.pop_front());
    model_push(d);
    check_state("push_rd_full");
    for (int n = 0; n < DEPTH; n++) begin
      pop();
      check_state("rd_drain");
    end

`ifdef UART_RX_PARITY_EN
    // parity: bit 1 on 0x03 is wrong for even parity, bit 0 is right
    send_frame(8'h03, 1'b1, 1'b1, -1, m);
    model_push(8'h03);
    pe_exp = 1'b1;
    check_state("par_bad");
    clear_err();
    send_frame(8'h03, 1'b1, 1'b0, -1, m);
    model_push(8'h03);
    check_state("par_good");
    pop();
    pop();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
